hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Sequencing controller for the ID stage of the 5-stage RISC-V pipeline.
- Detects load-use hazards and inserts bubbles; flushes IF/ID on a taken beq.
- Selects the immediate format for the sign-extend unit and flags illegal opcodes.
- Sits between the IF/ID register, the ID/EX register, the PC register and the sign-extend unit.

Parameters:
STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal range 1..3)
CNT_W, 16, width of the statistics counters (optional feature only)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  pipeline run enable
inst_i  in  32  instruction held in IF/ID
idex_memread_i  in  1  ID/EX instruction is a load
idex_rd_i  in  5  ID/EX destination register
branch_taken_i  in  1  beq comparison result, resolved in ID
pc_write_o  out  1  PC load enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID clear to NOP (0x00000000)
idex_bubble_o  out  1  force ID/EX control fields to zero
imm_sel_o  out  2  immediate format select: 0 NONE, 1 I, 2 S, 3 B
illegal_o  out  1  sticky illegal-opcode flag
stall_cnt_o  out  CNT_W  stall cycles counted (HAZARD_STATS_EN only)
flush_cnt_o  out  CNT_W  flushes counted (HAZARD_STATS_EN only)

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - illegal_o=0, stall counter=0, statistics counters=0.
  - Outputs take their IDLE values immediately.
- Decode (combinational, all states):
  - opc=inst_i[6:0], rs1=inst_i[19:15], rs2=inst_i[24:20].
  - imm_sel_o: 0010011 and 0000011 give I; 0100011 gives S; 1100011 gives B; everything else gives NONE.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011. inst_i==0 is a bubble and is legal.
- hazard (combinational) = idex_memread_i AND idex_rd_i!=0 AND (idex_rd_i==rs1 for R/I/ld/sd/beq, OR idex_rd_i==rs2 for R/sd/beq).
- Outputs are Mealy: they take effect in the same cycle as the triggering inputs.
- FSM states: IDLE, RUN, STALL, FLUSH.
- IDLE:
  - Outputs: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1.
  - Go to RUN on the edge where start_i=1.
- RUN, priority order:
  1. hazard: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. If STALL_CYCLES>1, load stall counter with STALL_CYCLES-1 and go to STALL; otherwise stay in RUN.
  2. opc==1100011 with branch_taken_i=1: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1. Go to FLUSH.
  3. Otherwise: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0.
- STALL:
  - Outputs as in the hazard case.
  - Decrement the counter each cycle; return to RUN when the counter reaches 0.
  - hazard is not re-evaluated in STALL.
- FLUSH:
  - Lasts exactly one cycle. Outputs as in RUN case 3.
  - branch_taken_i and hazard are ignored (ID holds the flushed NOP).
  - Return to RUN.
- Load-use beats branch: a beq whose operand depends on a load is stalled first, then resolved.
- Illegal opcode: in RUN, not stalling, inst_i!=0 and opc not in the legal set. illegal_o sets on the next edge and stays set until reset. The pipeline keeps running and imm_sel_o=NONE.
- start_i=0 in any state: go to IDLE on the next edge and abort any stall count. Statistics counters and illegal_o are held.
- Sign-extend output is don't-care when imm_sel_o=NONE.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - stall_cnt_o increments on every cycle with pc_write_o=0 while in RUN or STALL.
  - flush_cnt_o increments on every cycle with ifid_flush_o=1.
  - Both saturate at 2^CNT_W-1 and clear only on reset.
- Undefined: both ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset then start_i=1 with inst_i=0x00000013 (addi x0), no hazard -> pc_write_o=1 and imm_sel_o=1 from the first RUN cycle; illegal_o=0.
- idex_memread_i=1, idex_rd_i=5, inst_i=0x00528333 (add x6,x5,x5), STALL_CYCLES=2 -> pc_write_o=0 and idex_bubble_o=1 for exactly 2 cycles, then 1. With HAZARD_STATS_EN, stall_cnt_o=2.
- Same stimulus but idex_rd_i=0 -> no stall. Load to x5 followed by addi x6,x0,1 (rs1=0) -> no stall.
- inst_i=0x00000463 (beq x0,x0,+8), branch_taken_i=1 -> ifid_flush_o=1 for 1 cycle, then FLUSH ignores branch_taken_i=1 for 1 cycle; flush_cnt_o=1.
- inst_i=0x0000007F in RUN -> illegal_o=1 on the next edge and it persists across legal instructions. rst_i=0 asynchronously clears it without waiting for a clock edge.
- Hazard with STALL_CYCLES=3, start_i dropped in the second STALL cycle -> IDLE on the next edge with idex_bubble_o=1. start_i=1 restarts in RUN with no residual stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ID-stage sequencing: load-use stalls, beq flush, imm select, illegal flag.
// Optional statistics counters enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      inst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [1:0]       imm_sel_o,
  output logic             illegal_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] IMM_NONE = 2'd0;
  localparam logic [1:0] IMM_I    = 2'd1;
  localparam logic [1:0] IMM_S    = 2'd2;
  localparam logic [1:0] IMM_B    = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL,
    FLUSH
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic [6:0] opc;
  logic [4:0] rs1, rs2;
  logic       is_r, is_i, is_ld, is_sd, is_beq;
  logic       use_rs1, use_rs2;
  logic       hazard, legal, ill_set;

  assign opc = inst_i[6:0];
  assign rs1 = inst_i[19:15];
  assign rs2 = inst_i[24:20];

  assign is_r   = (opc == OP_R);
  assign is_i   = (opc == OP_I);
  assign is_ld  = (opc == OP_LD);
  assign is_sd  = (opc == OP_SD);
  assign is_beq = (opc == OP_BEQ);

  assign use_rs1 = is_r | is_i | is_ld | is_sd | is_beq;
  assign use_rs2 = is_r | is_sd | is_beq;

  assign hazard = idex_memread_i && (idex_rd_i != 5'd0) &&
                  ((use_rs1 && (idex_rd_i == rs1)) ||
                   (use_rs2 && (idex_rd_i == rs2)));

  // an all-zero word is the flushed NOP, not an illegal encoding
  assign legal   = use_rs1 || (inst_i == 32'd0);
  assign ill_set = (state_q == RUN) && !hazard && !legal;

  always_comb begin
    imm_sel_o = IMM_NONE;
    unique case (1'b1)
      is_i, is_ld: imm_sel_o = IMM_I;
      is_sd:       imm_sel_o = IMM_S;
      is_beq:      imm_sel_o = IMM_B;
      default:     imm_sel_o = IMM_NONE;
    endcase
  end

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b1;
    state_d       = state_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (hazard) begin
          if (STALL_CYCLES > 1) begin
            cnt_d   = 2'(STALL_CYCLES - 1);
            state_d = STALL;
          end
        end else if (is_beq && branch_taken_i) begin
          pc_write_o    = 1'b1;
          ifid_write_o  = 1'b1;
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b0;
          state_d       = FLUSH;
        end else begin
          pc_write_o    = 1'b1;
          ifid_write_o  = 1'b1;
          idex_bubble_o = 1'b0;
        end
      end
      STALL: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RUN;
      end
      FLUSH: begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        state_d       = RUN;
      end
      default: state_d = IDLE;
    endcase
    // dropping run enable wins over everything and aborts a stall
    if (!start_i) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      illegal_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ill_set) illegal_o <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic stall_inc, flush_inc;

  assign stall_inc = !pc_write_o &&
                     ((state_q == RUN) || (state_q == STALL));
  assign flush_inc = ifid_flush_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_inc && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_inc && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (STALL_CYCLES=2 and =3 copies).
// Expected output bundles are queued on drive and popped at the sample edge.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] inst_i;
  logic        idex_memread_i;
  logic [4:0]  idex_rd_i;
  logic        branch_taken_i;

  logic       pc2, ifw2, fl2, bub2, ill2;
  logic [1:0] imm2;
  logic       pc3, ifw3, fl3, bub3, ill3;
  logic [1:0] imm3;
`ifdef HAZARD_STATS_EN
  logic [15:0] scnt2, fcnt2, scnt3, fcnt3;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    bit         use3;
    logic [6:0] e;
  } exp_t;

  exp_t q[$];

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.STALL_CYCLES(2), .CNT_W(16)) d2 (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .inst_i         (inst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .branch_taken_i (branch_taken_i),
    .pc_write_o     (pc2),
    .ifid_write_o   (ifw2),
    .ifid_flush_o   (fl2),
    .idex_bubble_o  (bub2),
    .imm_sel_o      (imm2),
    .illegal_o      (ill2)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt_o    (scnt2),
    .flush_cnt_o    (fcnt2)
`endif
  );

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) d3 (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .inst_i         (inst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .branch_taken_i (branch_taken_i),
    .pc_write_o     (pc3),
    .ifid_write_o   (ifw3),
    .ifid_flush_o   (fl3),
    .idex_bubble_o  (bub3),
    .imm_sel_o      (imm3),
    .illegal_o      (ill3)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt_o    (scnt3),
    .flush_cnt_o    (fcnt3)
`endif
  );

  // bundle = {pc_write, ifid_write, ifid_flush, idex_bubble, imm_sel, illegal}
  task automatic cyc(input string tag, input bit use3, input logic [6:0] e);
    exp_t       x;
    logic [6:0] obs;
    q.push_back('{tag, use3, e});
    @(negedge clk_i);
    x   = q.pop_front();
    obs = x.use3 ? {pc3, ifw3, fl3, bub3, imm3, ill3}
                 : {pc2, ifw2, fl2, bub2, imm2, ill2};
    checks++;
    assert (obs === x.e)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", x.tag, obs, x.e);
    end
    @(posedge clk_i);
    #1;
  endtask

`ifdef HAZARD_STATS_EN
  task automatic chk_cnt(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    rst_i          = 1'b0;
    start_i        = 1'b0;
    inst_i         = 32'd0;
    idex_memread_i = 1'b0;
    idex_rd_i      = 5'd0;
    branch_taken_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    cyc("reset_idle", 0, 7'b0001_00_0);
    start_i = 1'b1;
    inst_i  = 32'h0000_0013;
    cyc("idle_start", 0, 7'b0001_01_0);
    cyc("run_addi", 0, 7'b1100_01_0);
    cyc("run_addi_d3", 1, 7'b1100_01_0);

    idex_memread_i = 1'b1;
    idex_rd_i      = 5'd5;
    inst_i         = 32'h0052_8333;
    cyc("hz_stall0", 0, 7'b0001_00_0);
    cyc("hz_stall1", 0, 7'b0001_00_0);
    idex_memread_i = 1'b0;
    cyc("hz_resume", 0, 7'b1100_00_0);
`ifdef HAZARD_STATS_EN
    chk_cnt("stall_cnt", scnt2, 16'd2);
`endif

    idex_memread_i = 1'b1;
    idex_rd_i      = 5'd0;
    cyc("rd0_nostall", 0, 7'b1100_00_0);
    idex_rd_i = 5'd5;
    inst_i    = 32'h0010_0313;
    cyc("rs1x0_nostall", 0, 7'b1100_01_0);
    cyc("rs1x0_nostall_d3", 1, 7'b1100_01_0);
    idex_memread_i = 1'b0;

    inst_i         = 32'h0000_0463;
    branch_taken_i = 1'b1;
    cyc("beq_flush", 0, 7'b1110_11_0);
    cyc("flush_ignores", 0, 7'b1100_11_0);
    branch_taken_i = 1'b0;
    cyc("after_flush", 0, 7'b1100_11_0);
`ifdef HAZARD_STATS_EN
    chk_cnt("flush_cnt", fcnt2, 16'd1);
`endif

    idex_memread_i = 1'b1;
    idex_rd_i      = 5'd5;
    inst_i         = 32'h0002_8463;
    branch_taken_i = 1'b1;
    cyc("ldbeq_stall0", 0, 7'b0001_11_0);
    cyc("ldbeq_stall1", 0, 7'b0001_11_0);
    idex_memread_i = 1'b0;
    cyc("ldbeq_flush", 0, 7'b1110_11_0);
    cyc("ldbeq_flushst", 0, 7'b1100_11_0);
    branch_taken_i = 1'b0;
    inst_i         = 32'h0000_0013;
    cyc("resync", 0, 7'b1100_01_0);

    inst_i = 32'h0000_007F;
    cyc("illegal_op", 0, 7'b1100_00_0);
    inst_i = 32'h0000_0013;
    cyc("illegal_set", 0, 7'b1100_01_1);
    inst_i = 32'h0052_8333;
    cyc("illegal_sticky", 0, 7'b1100_00_1);

    rst_i = 1'b0;
    cyc("async_rst", 0, 7'b0001_00_0);
`ifdef HAZARD_STATS_EN
    chk_cnt("stall_cnt_rst", scnt2, 16'd0);
    chk_cnt("flush_cnt_rst", fcnt2, 16'd0);
`endif
    rst_i  = 1'b1;
    inst_i = 32'h0000_0013;
    cyc("restart_idle", 1, 7'b0001_01_0);
    cyc("restart_run", 1, 7'b1100_01_0);

    idex_memread_i = 1'b1;
    idex_rd_i      = 5'd5;
    inst_i         = 32'h0052_8333;
    cyc("s3_hz", 1, 7'b0001_00_0);
    cyc("s3_stall1", 1, 7'b0001_00_0);
    start_i = 1'b0;
    cyc("s3_stall2_drop", 1, 7'b0001_00_0);
    start_i        = 1'b1;
    idex_memread_i = 1'b0;
    inst_i         = 32'h0000_0013;
    cyc("s3_idle", 1, 7'b0001_01_0);
    cyc("s3_run_clean", 1, 7'b1100_01_0);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain observed %0d expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
